// File: rtl/game_sequencer.sv
// Frogger round controller: sequences START/PLAY/PAUSE/HIT/SCORE/OVER, paces obstacles,
// tracks lives and score, and composes the red/green LED arrays. Requires TICK_BASE > 15*TICK_STEP.
module game_sequencer #(
    parameter int unsigned TICK_BASE    = 1024,
    parameter int unsigned TICK_STEP    = 60,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned FLASH_CYCLES = 512,
    parameter int unsigned WIN_TARGET   = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pause,
    input  logic [3:0]      level,
    input  logic [7:0][7:0] frog_array,
    input  logic [7:0][7:0] obs_array,
    output logic            obs_step,
    output logic            frog_en,
    output logic            round_reset,
    output logic [7:0][7:0] red_out,
    output logic [7:0][7:0] green_out,
    output logic [2:0]      score,
    output logic [1:0]      lives,
    output logic            game_over,
    output logic            won
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BASE_W     = CNT_W'(TICK_BASE);
    localparam logic [CNT_W-1:0] STEP_W     = CNT_W'(TICK_STEP);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [2:0]       WIN_SCORE  = 3'(WIN_TARGET);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HIT   = 3'd3,
        ST_SCORE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [2:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic             game_over_q, game_over_d;
    logic             won_q, won_d;

    logic collision_c;
    logic crossed_c;

    assign collision_c = |(frog_array & obs_array);
    assign crossed_c   = |frog_array[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_START;
            tick_cnt_q  <= '0;
            flash_cnt_q <= '0;
            period_q    <= BASE_W;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            period_q    <= period_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            won_q       <= won_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        flash_cnt_d = flash_cnt_q;
        period_d    = period_q;
        score_d     = score_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        won_d       = won_q;
        obs_step    = 1'b0;
        frog_en     = 1'b0;
        round_reset = 1'b0;

        unique case (state_q)
            ST_START: begin
                round_reset = 1'b1;
                period_d    = BASE_W - CNT_W'(level) * STEP_W;
                tick_cnt_d  = '0;
                flash_cnt_d = '0;
                state_d     = ST_PLAY;
            end
            ST_PLAY: begin
                frog_en = 1'b1;
                if (tick_cnt_q == period_q - CNT_W'(1)) begin
                    obs_step   = 1'b1;
                    tick_cnt_d = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                end
                // Collision outranks a crossing in the same cycle
                if (collision_c) begin
                    state_d = ST_HIT;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end else if (crossed_c) begin
                    state_d = ST_SCORE;
                    score_d = (score_q == 3'd7) ? 3'd7 : score_q + 3'd1;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_d = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (flash_cnt_q == FLASH_LAST) begin
                    flash_cnt_d = '0;
                    if (lives_q == 2'd0) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        won_d       = 1'b0;
                    end else begin
                        state_d = ST_START;
                    end
                end else begin
                    flash_cnt_d = flash_cnt_q + CNT_W'(1);
                end
            end
            ST_SCORE: begin
                if (flash_cnt_q == FLASH_LAST) begin
                    flash_cnt_d = '0;
                    if (score_q == WIN_SCORE) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        won_d       = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end else begin
                    flash_cnt_d = flash_cnt_q + CNT_W'(1);
                end
            end
            ST_OVER: begin
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // LED composition from the registered state and the live arrays
    always_comb begin
        red_out   = obs_array;
        green_out = frog_array;
        unique case (state_q)
            ST_HIT: begin
                red_out   = obs_array | frog_array;
                green_out = '0;
            end
            ST_SCORE: begin
                red_out      = '0;
                green_out    = frog_array;
                green_out[7] = 8'hFF;
            end
            ST_OVER: begin
                red_out   = won_q ? '0 : '1;
                green_out = won_q ? '1 : '0;
            end
            default: begin
            end
        endcase
    end

    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign won       = won_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scenario bench for game_sequencer; expectations are derived arithmetically from the game rules.
module tb_game_sequencer;

    localparam int unsigned P_BASE  = 16;
    localparam int unsigned P_STEP  = 2;
    localparam int unsigned P_FLASH = 8;

    logic            clk;
    logic            reset;
    logic            pause;
    logic [3:0]      level;
    logic [7:0][7:0] frog_array;
    logic [7:0][7:0] obs_array;
    logic            obs_step;
    logic            frog_en;
    logic            round_reset;
    logic [7:0][7:0] red_out;
    logic [7:0][7:0] green_out;
    logic [2:0]      score;
    logic [1:0]      lives;
    logic            game_over;
    logic            won;

    int n_cmp;
    int n_bad;

    game_sequencer #(
        .TICK_BASE(16), .TICK_STEP(2), .LIVES(2), .FLASH_CYCLES(8), .WIN_TARGET(2)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause), .level(level),
        .frog_array(frog_array), .obs_array(obs_array),
        .obs_step(obs_step), .frog_en(frog_en), .round_reset(round_reset),
        .red_out(red_out), .green_out(green_out),
        .score(score), .lives(lives), .game_over(game_over), .won(won)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges; returns sampling the START cycle
    task automatic do_reset(input int lv);
        level      = 4'(lv);
        pause      = 1'b0;
        frog_array = '0;
        obs_array  = '0;
        reset      = 1'b1;
        clk_step();
        clk_step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0][7:0] f;
        logic [7:0][7:0] o;
        do_reset(0);
        n_cmp++; if (round_reset !== 1'b1) begin n_bad++; $display("FAIL reset_round_reset got %b exp 1", round_reset); end
        n_cmp++; if (frog_en !== 1'b0) begin n_bad++; $display("FAIL reset_frog_en got %b exp 0", frog_en); end
        n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL reset_lives got %0d exp 2", lives); end
        n_cmp++; if (score !== 3'd0) begin n_bad++; $display("FAIL reset_score got %0d exp 0", score); end
        n_cmp++; if (game_over !== 1'b0 || won !== 1'b0) begin n_bad++; $display("FAIL reset_over got %b/%b exp 0/0", game_over, won); end
        for (int n = 0; n < 48; n++) begin
            clk_step();
            n_cmp++; if (obs_step !== ((n % P_BASE) == P_BASE - 1)) begin n_bad++; $display("FAIL base_period n=%0d obs_step got %b", n, obs_step); end
            n_cmp++; if (frog_en !== 1'b1 || round_reset !== 1'b0) begin n_bad++; $display("FAIL play_ctrl n=%0d got en=%b rr=%b exp 1/0", n, frog_en, round_reset); end
            if (n >= 16) begin
                n_cmp++; if (red_out !== obs_array || green_out !== frog_array) begin n_bad++; $display("FAIL play_display n=%0d got %h/%h exp %h/%h", n, red_out, green_out, obs_array, frog_array); end
                // Random non-overlapping arrays with an empty far bank keep the round in PLAY
                o = {32'($urandom), 32'($urandom)};
                f = {32'($urandom), 32'($urandom)} & ~o;
                o[7] = 8'h00;
                f[7] = 8'h00;
                obs_array  = o;
                frog_array = f;
            end
        end
    endtask

    task automatic test_level(input int lv);
        int p;
        p = P_BASE - lv * P_STEP;
        do_reset(lv);
        for (int n = 0; n < 3 * p; n++) begin
            clk_step();
            if (n == 0) level = 4'd0;
            n_cmp++; if (obs_step !== ((n % p) == p - 1)) begin n_bad++; $display("FAIL level%0d_period n=%0d obs_step got %b", lv, n, obs_step); end
        end
        frog_array[7] = 8'h10;
        clk_step();
        n_cmp++; if (score !== 3'd1) begin n_bad++; $display("FAIL level%0d_score got %0d exp 1", lv, score); end
        frog_array = '0;
        for (int k = 1; k < int'(P_FLASH); k++) clk_step();
        clk_step();
        n_cmp++; if (round_reset !== 1'b1) begin n_bad++; $display("FAIL level%0d_restart got %b exp 1", lv, round_reset); end
        for (int n = 0; n < 2 * int'(P_BASE); n++) begin
            clk_step();
            n_cmp++; if (obs_step !== ((n % P_BASE) == P_BASE - 1)) begin n_bad++; $display("FAIL level%0d_relatch n=%0d obs_step got %b", lv, n, obs_step); end
        end
    endtask

    task automatic test_pause(input int pre, input int dur);
        int p;
        int r_hit;
        p = P_BASE - 3 * P_STEP;
        r_hit = p - 1 - pre;
        do_reset(3);
        for (int n = 0; n <= pre; n++) clk_step();
        pause = 1'b1;
        for (int k = 1; k <= dur; k++) begin
            clk_step();
            n_cmp++; if (obs_step !== 1'b0 || frog_en !== 1'b0) begin n_bad++; $display("FAIL pause_hold k=%0d got step=%b en=%b exp 0/0", k, obs_step, frog_en); end
        end
        pause = 1'b0;
        for (int r = 1; r <= r_hit + p; r++) begin
            clk_step();
            n_cmp++; if (obs_step !== (r == r_hit || r == r_hit + p)) begin n_bad++; $display("FAIL pause_resume pre=%0d r=%0d obs_step got %b", pre, r, obs_step); end
        end
    endtask

    task automatic test_hit();
        logic [7:0][7:0] exp_red;
        int rr;
        do_reset(0);
        for (int n = 0; n <= int'($urandom_range(0, 20)); n++) clk_step();
        frog_array[0] = 8'h08;
        obs_array[0]  = 8'h08;
        clk_step();
        n_cmp++; if (lives !== 2'd1) begin n_bad++; $display("FAIL hit1_lives got %0d exp 1", lives); end
        exp_red = '0;
        exp_red[0] = 8'h08;
        n_cmp++; if (red_out !== exp_red || green_out !== '0) begin n_bad++; $display("FAIL hit1_display got %h/%h exp %h/0", red_out, green_out, exp_red); end
        n_cmp++; if (frog_en !== 1'b0) begin n_bad++; $display("FAIL hit1_frog_en got %b exp 0", frog_en); end
        frog_array = '0;
        obs_array  = '0;
        for (int k = 1; k < int'(P_FLASH); k++) begin
            clk_step();
            n_cmp++; if (round_reset !== 1'b0 || obs_step !== 1'b0) begin n_bad++; $display("FAIL hit1_flash k=%0d got rr=%b step=%b", k, round_reset, obs_step); end
        end
        clk_step();
        n_cmp++; if (round_reset !== 1'b1 || lives !== 2'd1) begin n_bad++; $display("FAIL hit1_restart got rr=%b lives=%0d exp 1/1", round_reset, lives); end
        clk_step();
        rr = int'($urandom_range(0, 6));
        frog_array[rr] = 8'(1 << $urandom_range(0, 7));
        obs_array[rr]  = frog_array[rr] | 8'($urandom);
        exp_red = obs_array | frog_array;
        clk_step();
        n_cmp++; if (lives !== 2'd0 || red_out !== exp_red) begin n_bad++; $display("FAIL hit2 got lives=%0d red=%h exp 0/%h", lives, red_out, exp_red); end
        frog_array = '0;
        obs_array  = '0;
        for (int k = 1; k < int'(P_FLASH); k++) clk_step();
        for (int k = 0; k < 6; k++) begin
            clk_step();
            n_cmp++; if (game_over !== 1'b1 || won !== 1'b0) begin n_bad++; $display("FAIL lose_over k=%0d got %b/%b exp 1/0", k, game_over, won); end
            n_cmp++; if (red_out !== '1 || green_out !== '0 || round_reset !== 1'b0 || frog_en !== 1'b0) begin n_bad++; $display("FAIL lose_display k=%0d got %h/%h rr=%b en=%b", k, red_out, green_out, round_reset, frog_en); end
            obs_array = {32'($urandom), 32'($urandom)};
        end
    endtask

    task automatic test_win();
        logic [7:0][7:0] exp_green;
        do_reset(int'($urandom_range(0, 7)));
        for (int round = 1; round <= 2; round++) begin
            for (int n = 0; n <= int'($urandom_range(1, 12)); n++) clk_step();
            frog_array[7] = 8'h10;
            frog_array[2] = 8'($urandom);
            clk_step();
            n_cmp++; if (score !== 3'(round)) begin n_bad++; $display("FAIL win_score round=%0d got %0d", round, score); end
            exp_green = frog_array;
            exp_green[7] = 8'hFF;
            n_cmp++; if (green_out !== exp_green || red_out !== '0) begin n_bad++; $display("FAIL win_display got %h/%h exp %h/0", green_out, red_out, exp_green); end
            frog_array = '0;
            for (int k = 1; k < int'(P_FLASH); k++) clk_step();
            clk_step();
            if (round == 1) begin
                n_cmp++; if (round_reset !== 1'b1 || game_over !== 1'b0) begin n_bad++; $display("FAIL win_restart got rr=%b over=%b exp 1/0", round_reset, game_over); end
            end
        end
        n_cmp++; if (game_over !== 1'b1 || won !== 1'b1) begin n_bad++; $display("FAIL win_over got %b/%b exp 1/1", game_over, won); end
        n_cmp++; if (green_out !== '1 || red_out !== '0) begin n_bad++; $display("FAIL win_over_display got %h/%h", green_out, red_out); end
    endtask

    task automatic test_priority();
        do_reset(0);
        for (int n = 0; n < 3; n++) clk_step();
        frog_array[7] = 8'h10;
        obs_array[7]  = 8'h10;
        clk_step();
        n_cmp++; if (lives !== 2'd1 || score !== 3'd0) begin n_bad++; $display("FAIL prio got lives=%0d score=%0d exp 1/0", lives, score); end
        n_cmp++; if (green_out !== '0) begin n_bad++; $display("FAIL prio_display got %h exp 0", green_out); end
        frog_array = '0;
        obs_array  = '0;
        clk_step();
        clk_step();
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        n_cmp++; if (round_reset !== 1'b1 || lives !== 2'd2 || score !== 3'd0) begin n_bad++; $display("FAIL midhit_reset got rr=%b lives=%0d score=%0d exp 1/2/0", round_reset, lives, score); end
        clk_step();
        n_cmp++; if (frog_en !== 1'b1) begin n_bad++; $display("FAIL midhit_replay got %b exp 1", frog_en); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        pause      = 1'b0;
        level      = 4'd0;
        frog_array = '0;
        obs_array  = '0;
        test_reset();
        test_level(3);
        test_level(7);
        test_level(int'($urandom_range(1, 6)));
        test_pause(4, 25);
        for (int i = 0; i < 3; i++) test_pause(int'($urandom_range(0, 8)), int'($urandom_range(1, 30)));
        test_hit();
        test_win();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level round controller for the Frogger game. Sequences the frog and obstacle blocks and owns the red/green arrays sent to the LED matrix driver. Generates the level-dependent obstacle step pulse, detects collision and win, tracks lives and score, and issues round resets. Replaces ad-hoc resetGame/hardReset wiring between the lose and count logic in the DE1_SoC top level.

Parameters:
TICK_BASE, 1024, obstacle step period in clk cycles at level 0
TICK_STEP, 60, period reduction per level unit
LIVES, 3, lives at game start (1..3)
FLASH_CYCLES, 512, hold time of HIT and SCORE display
WIN_TARGET, 7, scored crossings that end the game as a win (1..7)

Ports:
clk  in  1  system clock (divided clock in top level)
reset  in  1  synchronous, active-high
pause  in  1  level-sensitive pause request (synchronised)
level  in  4  speed select, 0 = slowest
frog_array  in  64  [7:0][7:0] frog position, row 7 = far bank
obs_array  in  64  [7:0][7:0] obstacle positions
obs_step  out  1  one-cycle pulse, obstacle block advances one column
frog_en  out  1  frog block may accept moves
round_reset  out  1  one-cycle pulse, frog and obstacles return to start
red_out  out  64  red array to LED matrix driver
green_out  out  64  green array to LED matrix driver
score  out  3  completed crossings
lives  out  2  remaining lives
game_over  out  1  game finished
won  out  1  valid when game_over, 1 = win

Behaviour:
- Reset (sync, clk edge with reset=1): state=START, tick_cnt=0, flash_cnt=0, score=0, lives=LIVES, period_q=TICK_BASE, game_over=0, won=0. Reset dominates all inputs.
- States: START, PLAY, PAUSE, HIT, SCORE, OVER (3-bit register).
- START: round_reset=1, frog_en=0, obs_step=0. Latch period_q = TICK_BASE - level*TICK_STEP (16-bit unsigned). Clear tick_cnt. Always -> PLAY next cycle. Level changes mid-round take effect only at the next START.
- PLAY: frog_en=1. tick_cnt increments each cycle. When tick_cnt==period_q-1: obs_step=1 for that cycle and tick_cnt wraps to 0.
- PLAY exit priority, evaluated each cycle:
  - Collision (|(frog_array & obs_array)) -> HIT. lives decrements on entry (no underflow).
  - Else win (|frog_array[7]) -> SCORE. score increments on entry.
  - Else pause=1 -> PAUSE.
  - obs_step may still pulse in the exit cycle.
- PAUSE: frog_en=0, obs_step=0, tick_cnt held. pause=0 -> PLAY, count resumes from held value. Collision/win not evaluated.
- HIT: frog_en=0, obs_step=0. flash_cnt counts 0..FLASH_CYCLES-1, then clears. Exit when flash_cnt==FLASH_CYCLES-1: to OVER with won=0 if lives==0, else to START. Pause ignored.
- SCORE: same timing as HIT. Exit to OVER with won=1 if score==WIN_TARGET, else to START.
- OVER: game_over=1, frog_en=0, obs_step=0, round_reset=0. Held until reset.
- Display, combinational from registered state and inputs:
  - PLAY/PAUSE/START: red_out=obs_array, green_out=frog_array.
  - HIT: red_out=obs_array|frog_array, green_out=0.
  - SCORE: green_out row 7 = 8'hFF, other rows = frog_array, red_out=0.
  - OVER: all-ones red (won=0) or all-ones green (won=1), other colour 0.
- Counters:
  - score saturates at 7.
  - tick_cnt and flash_cnt 16-bit.
  - period_q <1 is a parameter error. Document TICK_BASE > 15*TICK_STEP.

Test Plan:
Sim params for all tests: TICK_BASE=16, TICK_STEP=2, FLASH_CYCLES=8, LIVES=2, WIN_TARGET=2.

- Reset, level=0, empty arrays -> round_reset=1 one cycle after reset, then obs_step every 16 cycles. lives=2, score=0, game_over=0.
- level=3 at START -> obs_step period 10 cycles. Change level to 0 mid-PLAY -> period stays 10 until next START.
- pause=1 for 25 cycles at tick_cnt=5 -> no obs_step, frog_en=0. Release -> next obs_step exactly 10 cycles after pause entry minus the 5 already elapsed (i.e. 5 cycles after release, level 3).
- frog_array[0]=obs_array[0]=8'h08 -> HIT, lives=1, red_out[0]=8'h08, 8 cycles later round_reset pulse. Second collision -> lives=0, OVER, won=0, red_out all 64'hFF..FF.
- frog_array[7]=8'h10 twice (no collision) -> score 1 then 2. After second SCORE hold -> OVER, won=1, green_out all ones.
- Collision and frog_array[7]!=0 same cycle -> HIT taken, score unchanged. reset asserted during HIT -> START next cycle, lives=2.
